cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_hs_pkg.sv | 32 +++
 rtl/cdc_handshake_tx_sync.sv | 52 +++++
 rtl/cdc_handshake_tx.sv | 168 ++++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_hs_pkg                                                   |
// | Description : Shared types and default constants for the 4-phase CDC      |
// |               handshake transmitter (cdc_handshake_tx).                   |
// | Contents    : cdc_hs_state_e state enum, default parameter constants,     |
// |               state_is_busy() helper.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cdc_hs_pkg;

  // Default parameter values for cdc_handshake_tx.
  localparam int C_DEF_DATA_WIDTH     = 32;
  localparam int C_DEF_NUM_LEVELS     = 2;
  localparam int C_DEF_TIMEOUT_CYCLES = 1024;

  // Transmitter state. ERROR is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    ERROR   = 2'd3
  } cdc_hs_state_e;

  // A transfer is in progress in every state except IDLE (ERROR included).
  function automatic logic state_is_busy(input cdc_hs_state_e s);
    return (s != IDLE);
  endfunction

endpackage : cdc_hs_pkg
`default_nettype wire

// File: rtl/cdc_handshake_tx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_handshake_tx_sync                                        |
// | Description : Multi-flop level synchronizer bringing an asynchronous      |
// |               single-bit level into the i_clk domain.                     |
// | Parameters  : C_NUM_LEVELS - number of flops in the chain (>= 1)           |
// | Ports       : i_clk   - destination clock                                  |
// |               i_rst   - synchronous active-high reset, clears all flops    |
// |               i_async - asynchronous input level                           |
// |               o_sync  - synchronized level (output of the last flop)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdc_handshake_tx_sync
  import cdc_hs_pkg::*;
#(
  parameter int C_NUM_LEVELS = C_DEF_NUM_LEVELS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  // Flop 0 samples the asynchronous input and may go metastable; later
  // flops give it time to resolve before the level is used.
  logic [C_NUM_LEVELS-1:0] r_sync;

  generate
    if (C_NUM_LEVELS == 1) begin : g_single
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= i_async;
        end
      end
    end else begin : g_chain
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[C_NUM_LEVELS-2:0], i_async};
        end
      end
    end
  endgenerate

  assign o_sync = r_sync[C_NUM_LEVELS-1];

endmodule : cdc_handshake_tx_sync
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_handshake_tx                                             |
// | Description : Source side of a 4-phase req/ack clock-domain-crossing      |
// |               handshake. Accepts one payload from a valid/ready source,   |
// |               holds it on o_data and walks REQ -> RELEASE -> IDLE against |
// |               the synchronized acknowledge.                               |
// | Macro       : CDC_HS_TIMEOUT_EN - builds the watchdog, the ERROR state    |
// |               and the o_timeout port.                                      |
// | Parameters  : C_DATA_WIDTH     - payload width                             |
// |               C_NUM_LEVELS     - synchronizer depth on i_ack               |
// |               C_TIMEOUT_CYCLES - watchdog limit (watchdog build only)      |
// | Ports       : i_clk     - clock                                            |
// |               i_rst     - synchronous active-high reset                    |
// |               i_valid   - source offers i_data                             |
// |               o_ready   - transfer accepted this cycle if i_valid          |
// |               i_data    - payload                                          |
// |               o_req     - registered 4-phase request                       |
// |               o_data    - registered payload to destination                |
// |               i_ack     - asynchronous acknowledge from destination        |
// |               o_busy    - transfer in progress (state != IDLE)             |
// |               o_done    - one-cycle pulse on transfer completion           |
// |               o_timeout - sticky watchdog error (watchdog build only)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int C_DATA_WIDTH     = C_DEF_DATA_WIDTH,
  parameter int C_NUM_LEVELS     = C_DEF_NUM_LEVELS,
  parameter int C_TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [C_DATA_WIDTH-1:0] i_data,
  output logic                    o_req,
  output logic [C_DATA_WIDTH-1:0] o_data,
  input  logic                    i_ack,
  output logic                    o_busy,
  output logic                    o_done
`ifdef CDC_HS_TIMEOUT_EN
  ,
  output logic                    o_timeout
`endif
);

  cdc_hs_state_e           r_state;
  logic                    r_req;
  logic [C_DATA_WIDTH-1:0] r_data;
  logic                    r_done;
  logic                    w_ack_s;
  logic                    w_ready;

  cdc_handshake_tx_sync #(
    .C_NUM_LEVELS (C_NUM_LEVELS)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_ack),
    .o_sync  (w_ack_s)
  );

  // A stale acknowledge from a previous (possibly aborted) transfer must
  // fall before a new request may be raised, otherwise the destination
  // could not tell the two transfers apart.
  assign w_ready = (r_state == IDLE) && !w_ack_s;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_timeout;
  logic               w_cnt_last;

  // The counter is cleared when REQ/RELEASE is entered, so reaching the
  // limit on the next increment means C_TIMEOUT_CYCLES cycles were spent
  // waiting in the current phase.
  assign w_cnt_last = (r_cnt == C_CNT_W'(C_TIMEOUT_CYCLES - 1));
`else
  // Keeps the watchdog parameter referenced in the build without it.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (C_TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid && w_ready) begin
            r_data  <= i_data;
            r_req   <= 1'b1;
            r_state <= REQ;
`ifdef CDC_HS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end

        REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= RELEASE;
`ifdef CDC_HS_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ERROR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end

        RELEASE: begin
          if (!w_ack_s) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
`ifdef CDC_HS_TIMEOUT_EN
          end else if (w_cnt_last) begin
            r_timeout <= 1'b1;
            r_state   <= ERROR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end

`ifdef CDC_HS_TIMEOUT_EN
        // Terminal until reset: the handshake is in an unknown phase and
        // cannot be resumed safely.
        ERROR: begin
          r_req <= 1'b0;
        end
`endif

        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = w_ready;
  assign o_req   = r_req;
  assign o_data  = r_data;
  assign o_busy  = state_is_busy(r_state);
  assign o_done  = r_done;
`ifdef CDC_HS_TIMEOUT_EN
  assign o_timeout = r_timeout;
`endif

endmodule : cdc_handshake_tx
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cdc_handshake_tx                                          |
// | Description : Self-checking bench for cdc_handshake_tx. Stimulus pushes   |
// |               each accepted payload into a scoreboard queue; a monitor    |
// |               compares o_data while busy and pops on every o_done.        |
// |               CDC_HS_TIMEOUT_EN adds the watchdog scenario.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int NL = 2;
  localparam int TO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_req;
  logic [DW-1:0] o_data;
  logic          i_ack = 1'b0;
  logic          o_busy;
  logic          o_done;
`ifdef CDC_HS_TIMEOUT_EN
  logic          o_timeout;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  bit            ack_auto = 1'b0;

  always #5 i_clk = ~i_clk;

  cdc_handshake_tx #(
    .C_DATA_WIDTH     (DW),
    .C_NUM_LEVELS     (NL),
    .C_TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .o_req     (o_req),
    .o_data    (o_data),
    .i_ack     (i_ack),
    .o_busy    (o_busy),
    .o_done    (o_done)
`ifdef CDC_HS_TIMEOUT_EN
    ,
    .o_timeout (o_timeout)
`endif
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Destination model: acknowledge follows the request immediately.
  always @(negedge i_clk) begin
    if (ack_auto) i_ack = o_req;
  end

  // Scoreboard monitor.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_done) begin
        if (exp_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else                   check("done_data", 64'(o_data), 64'(exp_q.pop_front()));
      end else if (o_busy && exp_q.size() > 0) begin
        check("data_stable", 64'(o_data), 64'(exp_q[0]));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offer d, then count cycles from the accept edge to o_done.
  task automatic xfer(input logic [DW-1:0] d, input bit hold_valid, input int exp_lat);
    int n;
    bit ready_low;
    n = 0;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_accept", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_data  = d;
    exp_q.push_back(d);
    tick();
    if (hold_valid) i_data = ~d;
    else            i_valid = 1'b0;
    n = 0;
    ready_low = 1'b1;
    while (!o_done && n < 200) begin
      if (o_ready) ready_low = 1'b0;
      tick();
      n++;
    end
    i_valid = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    if (hold_valid) check("ready_low_in_xfer", 64'(ready_low), 64'd1);
  endtask

  initial begin
    int  n;
    bit  seen;

    // Reset state.
    repeat (3) tick();
    check("rst_req",   64'(o_req),   64'd0);
    check("rst_data",  64'(o_data),  64'd0);
    check("rst_done",  64'(o_done),  64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    tick();

    // Basic transfer with immediate ack: 2 + 2*2 = 6 cycles.
    ack_auto = 1'b1;
    xfer(32'hDEADBEEF, 1'b0, 6);
    tick();
    check("data_held_after_done", 64'(o_data), 64'hDEADBEEF);

    // i_valid held with changing data through REQ/RELEASE.
    xfer(32'h13579BDF, 1'b1, 6);
    tick();
    check("no_extra_accept", 64'(o_busy), 64'd0);
    xfer(32'h00000001, 1'b0, 6);

    // Slow destination: ack raised 3 cycles after accept, dropped 2 cycles
    // after o_req falls.
    ack_auto = 1'b0;
    i_ack    = 1'b0;
    tick();
    i_valid = 1'b1;
    i_data  = 32'h0F1E2D3C;
    exp_q.push_back(32'h0F1E2D3C);
    tick();
    i_valid = 1'b0;
    n = 0;
    repeat (3) begin tick(); n++; end
    check("slow_req_held", 64'(o_req), 64'd1);
    i_ack = 1'b1;
    while (o_req && n < 100) begin tick(); n++; end
    check("slow_req_fall", 64'(n), 64'd6);
    repeat (2) begin tick(); n++; end
    check("slow_no_early_done", 64'(o_done), 64'd0);
    i_ack = 1'b0;
    while (!o_done && n < 100) begin tick(); n++; end
    check("slow_latency", 64'(n), 64'd11);
    tick();

    // Reset mid-transfer aborts without o_done.
    i_valid = 1'b1;
    i_data  = 32'hA5A50F0F;
    exp_q.push_back(32'hA5A50F0F);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    check("abort_req_before", 64'(o_req), 64'd1);
    i_rst = 1'b1;
    tick();
    exp_q.delete();
    check("abort_req",  64'(o_req),  64'd0);
    check("abort_data", 64'(o_data), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    i_rst = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Stale ack held high out of reset blocks acceptance.
    i_ack = 1'b1;
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    repeat (3) tick();
    check("stale_ready_low", 64'(o_ready), 64'd0);
    i_valid = 1'b1;
    i_data  = 32'h12345678;
    seen    = 1'b0;
    repeat (4) begin
      tick();
      if (o_busy) seen = 1'b1;
    end
    check("stale_no_accept", 64'(seen), 64'd0);
    i_valid = 1'b0;
    i_ack   = 1'b0;
    tick();
    check("stale_ready_still_low", 64'(o_ready), 64'd0);
    tick();
    check("stale_ready_released", 64'(o_ready), 64'd1);
    ack_auto = 1'b1;
    xfer(32'hCAFEF00D, 1'b0, 6);
    tick();
    ack_auto = 1'b0;
    i_ack    = 1'b0;

`ifdef CDC_HS_TIMEOUT_EN
    // Watchdog: no ack at all, ERROR after 16 cycles in REQ.
    i_valid = 1'b1;
    i_data  = 32'h5A5A5A5A;
    exp_q.push_back(32'h5A5A5A5A);
    tick();
    i_valid = 1'b0;
    n = 0;
    while (!o_timeout && n < 100) begin tick(); n++; end
    check("to_cycles", 64'(n), 64'd16);
    check("to_req",    64'(o_req),   64'd0);
    check("to_busy",   64'(o_busy),  64'd1);
    check("to_ready",  64'(o_ready), 64'd0);
    i_ack = 1'b1;
    repeat (6) tick();
    i_ack = 1'b0;
    repeat (6) tick();
    check("to_sticky",      64'(o_timeout), 64'd1);
    check("to_sticky_busy", 64'(o_busy),    64'd1);
    check("to_sticky_req",  64'(o_req),     64'd0);
    i_rst = 1'b1;
    tick();
    exp_q.delete();
    check("to_cleared", 64'(o_timeout), 64'd0);
    check("to_rst_busy", 64'(o_busy),   64'd0);
    i_rst = 1'b0;
    tick();
`else
    // No watchdog: the request is held for as long as the ack is absent.
    i_valid = 1'b1;
    i_data  = 32'h5A5A5A5A;
    exp_q.push_back(32'h5A5A5A5A);
    tick();
    i_valid = 1'b0;
    repeat (40) tick();
    check("wait_req",  64'(o_req),  64'd1);
    check("wait_busy", 64'(o_busy), 64'd1);
    ack_auto = 1'b1;
    n = 0;
    while (!o_done && n < 100) begin tick(); n++; end
    check("wait_completes", 64'(o_done), 64'd1);
    tick();
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $fatal(1);
  end

endmodule : tb_cdc_handshake_tx
`default_nettype wire
